// File: rtl/segment_display_sched.sv
// Round-robin sharing of a two-digit seven-segment display between NUM_REQ
// requesters; the granted 8-bit value goes through a serial double-dabble BCD conversion.
module segment_display_sched #(
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 1000000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [8*NUM_REQ-1:0]       val_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] src_o,
  output logic [8:0]                 segment_led_1_o,
  output logic [8:0]                 segment_led_2_o
);

  localparam int          SW   = $clog2(NUM_REQ);
  localparam int          HW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned NR_U = NUM_REQ;

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic [SW-1:0]       src_q, src_d;
  logic [SW-1:0]       last_q, last_d;
  logic [8:0]          led1_q, led1_d;
  logic [8:0]          led2_q, led2_d;
  logic [2:0]          it_q, it_d;
  logic [7:0]          bin_q, bin_d;
  logic [9:0]          bcd_q, bcd_d;
  logic [HW-1:0]       hold_q, hold_d;

  logic          found;
  logic [SW-1:0] pick;
  logic [SW-1:0] cand;
  logic [3:0]    ones_adj, tens_adj;
  logic [17:0]   shifted;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3f;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5b;
      4'd3:    seg7 = 7'h4f;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6d;
      4'd6:    seg7 = 7'h7d;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7f;
      4'd9:    seg7 = 7'h6f;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // First asserted request searching upward from the last grant, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NR_U; i++) begin
      cand = SW'((32'(last_q) + i) % NR_U);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // One double-dabble step: correct nibbles >=5, then shift the whole {bcd,bin} left.
  always_comb begin
    ones_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    tens_adj = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    shifted  = {bcd_q[8], tens_adj, ones_adj, bin_q, 1'b0};
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    busy_d  = busy_q;
    src_d   = src_q;
    last_d  = last_q;
    led1_d  = led1_q;
    led2_d  = led2_q;
    it_d    = it_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = NUM_REQ'(1) << pick;
          bin_d   = val_i[8*pick +: 8];
          bcd_d   = '0;
          last_d  = pick;
          it_d    = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        bin_d = shifted[7:0];
        bcd_d = shifted[17:8];
        it_d  = it_q + 3'd1;
        if (it_q == 3'd7) begin
          // Display loads straight from the final shift so no partial value is ever shown.
          led1_d  = {1'b0, (shifted[17:16] >= 2'd2), seg7(shifted[15:12])};
          led2_d  = {1'b0, (shifted[17:16] != 2'd0), seg7(shifted[11:8])};
          src_d   = last_q;
          hold_d  = HW'(HOLD_CYCLES - 1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      src_q   <= '0;
      last_q  <= SW'(NUM_REQ - 1);
      led1_q  <= 9'h100;
      led2_q  <= 9'h100;
      it_q    <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      src_q   <= src_d;
      last_q  <= last_d;
      led1_q  <= led1_d;
      led2_q  <= led2_d;
      it_q    <= it_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_o           = gnt_q;
  assign busy_o          = busy_q;
  assign src_o           = src_q;
  assign segment_led_1_o = led1_q;
  assign segment_led_2_o = led2_q;

endmodule

// File: tb/tb_segment_display_sched.sv
// Scoreboard bench for segment_display_sched: grants are predicted by a round-robin
// model and each displayed value is predicted from decimal arithmetic on the granted input.
module tb_segment_display_sched;

  localparam int NR = 2;
  localparam int HC = 4;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [NR-1:0]   req_i;
  logic [8*NR-1:0] val_i;
  logic [NR-1:0]   gnt_o;
  logic            busy_o;
  logic [0:0]      src_o;
  logic [8:0]      segment_led_1_o;
  logic [8:0]      segment_led_2_o;

  always #5 clk = ~clk;

  segment_display_sched #(.NUM_REQ(NR), .HOLD_CYCLES(HC)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .val_i(val_i),
    .gnt_o(gnt_o), .busy_o(busy_o), .src_o(src_o),
    .segment_led_1_o(segment_led_1_o), .segment_led_2_o(segment_led_2_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [6:0] segtab [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};

  function automatic logic [8:0] exp_led(input int unsigned v, input bit tens);
    int unsigned h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    if (tens) exp_led = {1'b0, (h >= 2), segtab[t]};
    else      exp_led = {1'b0, (h >= 1), segtab[o]};
  endfunction

  typedef struct {
    int unsigned due;
    logic [18:0] disp;
  } exp_t;
  exp_t sb[$];

  logic [NR-1:0]   req_s;
  logic [8*NR-1:0] val_s;
  always @(posedge clk) begin
    req_s = req_i;
    val_s = val_i;
  end

  int unsigned cyc = 0;
  int          last_m = NR - 1;
  int          n_gnt = 0;
  int unsigned gcyc[$];
  logic [18:0] exp_disp = {1'b0, 9'h100, 9'h100};

  always @(negedge clk) begin
    int e;
    int unsigned v;
    exp_t ent;
    cyc++;
    if (rst_i) begin
      last_m   = NR - 1;
      sb.delete();
      exp_disp = {1'b0, 9'h100, 9'h100};
    end else begin
      if (gnt_o != '0) begin
        e = -1;
        for (int i = 1; i <= NR; i++) begin
          if (e < 0 && req_s[(last_m + i) % NR]) e = (last_m + i) % NR;
        end
        if (e < 0) begin
          check_val("gnt_spurious", 32'(gnt_o), 32'd0);
        end else begin
          check_val("gnt_rr", 32'(gnt_o), 32'(1) << e);
          last_m   = e;
          v        = 32'(val_s[8*e +: 8]);
          ent.due  = cyc + 8;
          ent.disp = {e[0], exp_led(v, 1'b1), exp_led(v, 1'b0)};
          sb.push_back(ent);
        end
        n_gnt++;
        gcyc.push_back(cyc);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_disp = sb[0].disp;
        sb.pop_front();
        check_val("display_update", {src_o, segment_led_1_o, segment_led_2_o}, exp_disp);
      end else begin
        check_val("display_hold", {src_o, segment_led_1_o, segment_led_2_o}, exp_disp);
      end
    end
  end

  task automatic wait_gnt(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt_o[k] && n < 200);
    if (!gnt_o[k]) check_val("gnt_timeout", 32'(gnt_o[k]), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check_val("idle_timeout", 32'(busy_o), 32'd0);
    @(negedge clk);
  endtask

  task automatic xact(input int k, input logic [7:0] v);
    @(negedge clk);
    val_i[8*k +: 8] = v;
    req_i[k] = 1'b1;
    wait_gnt(k);
    req_i[k] = 1'b0;
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n0;
    rst_i = 1'b1;
    req_i = '0;
    val_i = '0;
    repeat (3) @(negedge clk);
    check_val("rst_led1", 32'(segment_led_1_o), 32'h100);
    check_val("rst_led2", 32'(segment_led_2_o), 32'h100);
    check_val("rst_gnt",  32'(gnt_o), 32'd0);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    check_val("rst_src",  32'(src_o), 32'd0);
    #1 rst_i = 1'b0;

    // value 0, busy length
    @(negedge clk);
    val_i[7:0] = 8'd0;
    req_i[0]   = 1'b1;
    wait_gnt(0);
    req_i[0] = 1'b0;
    n = 0;
    while (busy_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_val("busy_len", 32'(n), 32'd12);
    check_val("zero_led1", 32'(segment_led_1_o), 32'h03f);
    check_val("zero_led2", 32'(segment_led_2_o), 32'h03f);
    check_val("zero_src",  32'(src_o), 32'd0);

    xact(0, 8'd123);
    check_val("v123_led1", 32'(segment_led_1_o), 32'h05b);
    check_val("v123_led2", 32'(segment_led_2_o), 32'h0cf);
    xact(0, 8'd255);
    xact(0, 8'd99);

    // late val change is ignored
    @(negedge clk);
    val_i[7:0] = 8'd42;
    req_i[0]   = 1'b1;
    wait_gnt(0);
    val_i[7:0] = 8'd7;
    req_i[0]   = 1'b0;
    wait_idle();
    check_val("late_val_led1", 32'(segment_led_1_o), 32'h066);
    check_val("late_val_led2", 32'(segment_led_2_o), 32'h05b);

    // requester 1 pulses during HOLD only
    @(negedge clk);
    val_i[7:0] = 8'd55;
    req_i[0]   = 1'b1;
    wait_gnt(0);
    req_i[0] = 1'b0;
    repeat (10) @(negedge clk);
    val_i[15:8] = 8'd200;
    req_i[1]    = 1'b1;
    @(negedge clk);
    req_i[1] = 1'b0;
    n0 = n_gnt;
    repeat (20) @(negedge clk);
    check_val("dropped_req_no_gnt", 32'(n_gnt), 32'(n0));

    // continuous contention
    @(negedge clk);
    val_i = {8'd250, 8'd17};
    req_i = 2'b11;
    n0 = n_gnt;
    n  = 0;
    while (n_gnt < n0 + 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    req_i = '0;
    check_val("rr_grants", 32'(n_gnt), 32'(n0 + 4));
    if (n_gnt >= n0 + 4) begin
      for (int i = 0; i < 3; i++)
        check_val("rr_period", gcyc[n0 + i + 1] - gcyc[n0 + i], 32'd13);
    end
    wait_idle();

    // reset mid-conversion
    @(negedge clk);
    val_i[15:8] = 8'd77;
    req_i[1]    = 1'b1;
    wait_gnt(1);
    req_i[1] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    check_val("midrst_led1", 32'(segment_led_1_o), 32'h100);
    check_val("midrst_led2", 32'(segment_led_2_o), 32'h100);
    check_val("midrst_gnt",  32'(gnt_o), 32'd0);
    check_val("midrst_busy", 32'(busy_o), 32'd0);
    check_val("midrst_src",  32'(src_o), 32'd0);
    @(negedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    val_i = {8'd99, 8'd88};
    req_i = 2'b11;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt_o == '0 && n < 200);
    req_i = '0;
    check_val("first_after_rst", 32'(gnt_o), 32'd1);
    wait_idle();
    check_val("v88_led1", 32'(segment_led_1_o), 32'h07f);
    check_val("v88_led2", 32'(segment_led_2_o), 32'h07f);

    repeat (5) @(negedge clk);
    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
